// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures the high time of an incoming PWM/servo pulse train and reports it
// in the generator's pulsewidth units (1 LSB = CLK_DIV / 2**WIDTH clocks).
// Also flags loss of signal (no rise for 2*CLK_DIV clocks) and a stuck-high
// input (high for CLK_DIV clocks).
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to add a 4-sample
// agreement filter after the synchronizer. It rejects pulses of 3 clocks or
// fewer and raises edge latency from 3 to 7 clock edges.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   en_i          capture enable; low forces IDLE within one cycle
//   pwm_sig_i     asynchronous PWM input
//   pulsewidth_o  last measured high time in LSBs, held between updates
//   valid_o       one-cycle strobe when pulsewidth_o updates
//   timeout_o     level: stuck-high or loss of signal, cleared by next valid
//   busy_o        high while a pulse is being measured
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int CLK_DIV = 2000000,
   parameter int WIDTH   = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             pwm_sig_i,
   output logic [WIDTH-1:0] pulsewidth_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             busy_o
);

   // Clocks per result LSB; CLK_DIV must be at least 2**WIDTH.
   localparam int TICK = CLK_DIV / (2 ** WIDTH);
   localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int HW   = $clog2(CLK_DIV + 1);
   localparam int GW   = $clog2(2 * CLK_DIV + 1);

   localparam logic [PW-1:0] TICK_LAST = PW'(TICK - 1);
   localparam logic [HW-1:0] HI_MAX    = HW'(CLK_DIV);
   localparam logic [GW-1:0] GAP_MAX   = GW'(2 * CLK_DIV);

   typedef enum logic [2:0] {IDLE, WAIT_LOW, ARMED, HIGH, STUCK} state_t;

   state_t           state_q;
   logic             s1_q, s2_q, s3_q;
   logic             lvl;
   logic             rise, fall;
   logic [PW-1:0]    prescale_q, prescale_d;
   logic [WIDTH:0]   lsb_q, lsb_d;
   logic [HW-1:0]    hi_cnt_q, hi_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] pw_sat;
   logic [WIDTH-1:0] pulsewidth_q;
   logic             valid_q, timeout_q;

   // Input path. Synchronizer flops reset to 1 so that a fake low is never
   // seen after reset: WAIT_LOW then only passes once a real low has made it
   // through, and a pulse already high at release is not measured.
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic [2:0] sh_q;
   logic       lvl_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q  <= 1'b1;
         s2_q  <= 1'b1;
         sh_q  <= '1;
         lvl_q <= 1'b1;
         s3_q  <= 1'b1;
      end else begin
         s1_q <= pwm_sig_i;
         s2_q <= s1_q;
         sh_q <= {sh_q[1:0], s2_q};
         // Filtered level follows only when four consecutive samples agree.
         if (&{sh_q, s2_q})
            lvl_q <= 1'b1;
         else if (~|{sh_q, s2_q})
            lvl_q <= 1'b0;
         s3_q <= lvl_q;
      end
   end

   assign lvl = lvl_q;
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= pwm_sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign lvl = s2_q;
`endif

   assign rise = lvl & ~s3_q;
   assign fall = ~lvl & s3_q;

   // Next counter values. The fall cycle itself is counted, so a pulse seen
   // high for N clocks reports floor(N / TICK) from lsb_d on the fall cycle.
   always_comb begin
      prescale_d = prescale_q + PW'(1);
      lsb_d      = lsb_q;
      if (prescale_q == TICK_LAST) begin
         prescale_d = '0;
         lsb_d      = lsb_q + (WIDTH+1)'(1);
      end
      hi_cnt_d  = (hi_cnt_q == HI_MAX)   ? hi_cnt_q  : hi_cnt_q + HW'(1);
      gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + GW'(1);
      pw_sat    = lsb_d[WIDTH] ? '1 : lsb_d[WIDTH-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         prescale_q   <= '0;
         lsb_q        <= '0;
         hi_cnt_q     <= '0;
         gap_cnt_q    <= '0;
         pulsewidth_q <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!en_i) begin
            // Disable beats everything, including a fall in the same cycle.
            state_q    <= IDLE;
            prescale_q <= '0;
            lsb_q      <= '0;
            hi_cnt_q   <= '0;
            gap_cnt_q  <= '0;
         end else begin
            case (state_q)
               IDLE: state_q <= WAIT_LOW;
               WAIT_LOW: begin
                  if (!s3_q)
                     state_q <= ARMED;
               end
               ARMED: begin
                  if (rise) begin
                     prescale_q <= '0;
                     lsb_q      <= '0;
                     hi_cnt_q   <= '0;
                     gap_cnt_q  <= '0;
                     state_q    <= HIGH;
                  end else begin
                     gap_cnt_q <= gap_cnt_d;
                     if (gap_cnt_d == GAP_MAX)
                        timeout_q <= 1'b1;
                  end
               end
               HIGH: begin
                  prescale_q <= prescale_d;
                  lsb_q      <= lsb_d;
                  hi_cnt_q   <= hi_cnt_d;
                  gap_cnt_q  <= gap_cnt_d;
                  // A fall on the threshold cycle is still a valid pulse.
                  if (fall) begin
                     pulsewidth_q <= pw_sat;
                     valid_q      <= 1'b1;
                     timeout_q    <= 1'b0;
                     state_q      <= ARMED;
                  end else if (hi_cnt_d == HI_MAX) begin
                     timeout_q <= 1'b1;
                     state_q   <= STUCK;
                  end
               end
               STUCK: begin
                  gap_cnt_q <= gap_cnt_d;
                  if (fall)
                     state_q <= ARMED;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pulsewidth_o = pulsewidth_q;
   assign valid_o      = valid_q;
   assign timeout_o    = timeout_q;
   assign busy_o       = (state_q == HIGH);

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   localparam int CLK_DIV = 2560;
   localparam int WIDTH   = 8;
   localparam int TICK    = CLK_DIV / (2 ** WIDTH);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT    = 7;
   localparam int MIN_HI = 4;
`else
   localparam int LAT    = 3;
   localparam int MIN_HI = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             pwm;
   logic [WIDTH-1:0] pw;
   logic             valid;
   logic             timeout;
   logic             busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int exp_q[$];
   int due_q[$];

   pwm_capture #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .pwm_sig_i    (pwm),
      .pulsewidth_o (pw),
      .valid_o      (valid),
      .timeout_o    (timeout),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: a clean high pulse of n clocks is reported as floor(n/TICK)
   // saturated to the result width, unless it is too short to pass the
   // filter or stays high longer than one PWM period.
   function automatic int ref_width(input int n);
      int w;
      w = n / TICK;
      return (w > (2 ** WIDTH) - 1) ? (2 ** WIDTH) - 1 : w;
   endfunction

   function automatic bit ref_reported(input int n);
      return (n >= MIN_HI) && (n <= CLK_DIV);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      int t;
      @(negedge clk);
      pwm = 1'b1;
      t   = cyc;
      wait_until(t + hi);
      pwm = 1'b0;
      if (ref_reported(hi)) begin
         exp_q.push_back(ref_width(hi));
         due_q.push_back(cyc + LAT);
      end
      wait_until(t + hi + lo);
   endtask

   // Monitor: every valid strobe must match the oldest expected result, at
   // the expected cycle, with timeout cleared.
   always @(negedge clk) begin : monitor
      int e;
      int d;
      if (valid === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: pulsewidth %0d at cycle %0d, no result expected", pw, cyc);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            if (int'(pw) != e || cyc != d || timeout !== 1'b0) begin
               fails++;
               $display("FAIL result: pulsewidth %0d cycle %0d timeout %0b, expected %0d cycle %0d timeout 0",
                        pw, cyc, timeout, e, d);
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      int f;
      rst_n = 1'b0;
      en    = 1'b0;
      pwm   = 1'b0;
      #20;
      check("reset_pulsewidth", int'(pw), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_timeout", int'(timeout), 0);
      check("reset_busy", int'(busy), 0);
      #30;
      rst_n = 1'b1;
      @(negedge clk);
      en = 1'b1;
      repeat (10) @(negedge clk);

      // Nominal 100-clock pulses at the PWM period.
      repeat (3) pulse(100, CLK_DIV - 100);
      check("nominal_pulsewidth", int'(pw), 10);
      check("nominal_timeout", int'(timeout), 0);

      // Rounding down and saturation, including fall exactly at the limit.
      pulse(25, 500);
      pulse(9, 500);
      pulse(2559, 500);
      pulse(CLK_DIV, 500);
      check("sat_pulsewidth", int'(pw), 255);

      // Stuck high.
      pulse(100, 300);
      @(negedge clk);
      pwm = 1'b1;
      t   = cyc;
      wait_until(t + LAT + CLK_DIV - 1);
      check("stuck_timeout_before", int'(timeout), 0);
      check("stuck_busy_before", int'(busy), 1);
      wait_until(t + LAT + CLK_DIV);
      check("stuck_timeout_set", int'(timeout), 1);
      check("stuck_busy_cleared", int'(busy), 0);
      wait_until(t + 3000);
      pwm = 1'b0;
      repeat (300) @(negedge clk);
      check("stuck_timeout_held", int'(timeout), 1);
      pulse(100, 300);
      check("stuck_recovered_timeout", int'(timeout), 0);
      check("stuck_recovered_pulsewidth", int'(pw), 10);

      // Loss of signal after one good pulse.
      @(negedge clk);
      pwm = 1'b1;
      t   = cyc;
      wait_until(t + 100);
      pwm = 1'b0;
      exp_q.push_back(ref_width(100));
      due_q.push_back(cyc + LAT);
      wait_until(t + LAT + 2 * CLK_DIV - 1);
      check("los_timeout_before", int'(timeout), 0);
      wait_until(t + LAT + 2 * CLK_DIV);
      check("los_timeout_set", int'(timeout), 1);
      check("los_pulsewidth_held", int'(pw), 10);
      wait_until(t + 6000);

      // Enable raised mid-pulse: that pulse is ignored.
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      pwm = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b1;
      repeat (50) @(negedge clk);
      pwm = 1'b0;
      repeat (100) @(negedge clk);
      pulse(100, 200);

      // Enable dropped mid-pulse.
      @(negedge clk);
      pwm = 1'b1;
      repeat (50) @(negedge clk);
      check("en_drop_busy_before", int'(busy), 1);
      en = 1'b0;
      @(negedge clk);
      check("en_drop_busy_after", int'(busy), 0);
      repeat (50) @(negedge clk);
      pwm = 1'b0;
      repeat (20) @(negedge clk);
      en = 1'b1;
      repeat (20) @(negedge clk);

      // Disable in the same cycle the fall is detected.
      @(negedge clk);
      pwm = 1'b1;
      t   = cyc;
      wait_until(t + 50);
      pwm = 1'b0;
      f   = cyc;
      wait_until(f + LAT - 1);
      en = 1'b0;
      wait_until(f + LAT);
      check("en_beats_fall_valid", int'(valid), 0);
      repeat (20) @(negedge clk);
      en = 1'b1;
      repeat (20) @(negedge clk);

      // Glitches: measured as 0 LSB without the filter, rejected with it.
      pulse(1, 100);
      pulse(2, 100);

      // Randomized pulse train.
      for (int i = 0; i < 24; i++)
         pulse($urandom_range(700, 1), $urandom_range(600, 20));

      // Reset in the middle of a measured pulse.
      pulse(100, 100);
      @(negedge clk);
      pwm = 1'b1;
      t   = cyc;
      wait_until(t + 30);
      check("rst_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_pulsewidth", int'(pw), 0);
      check("rst_mid_valid", int'(valid), 0);
      check("rst_mid_timeout", int'(timeout), 0);
      check("rst_mid_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      pwm = 1'b0;
      repeat (50) @(negedge clk);
      pulse(100, 100);
      check("post_reset_pulsewidth", int'(pw), 10);

      repeat (20) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_results: %0d expected results never strobed, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
